// File: rtl/otter_stream_mux_pkg.sv
// otter_stream_mux shared types.
// Arbitration modes, lock state and pointer helper.
package otter_mux_pkg;

    typedef enum {ARB_FIXED, ARB_RR, ARB_EXT} arb_mode_e;

    typedef enum logic {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } lock_state_e;

    function automatic int wrap_inc(int v, int n);
        return (v + 1) % n;
    endfunction

endpackage

// File: rtl/otter_stream_mux_if.sv
// Stream bundle between N producers, the mux and one consumer.
// slave = mux side, master = producer/consumer environment.
interface otter_stream_mux_if #(
    parameter int WIDTH  = 32,
    parameter int NUM_IN = 4
);
    localparam int SEL_W = $clog2(NUM_IN);

    logic [NUM_IN-1:0]       in_valid;
    logic [NUM_IN-1:0]       in_ready;
    logic [NUM_IN*WIDTH-1:0] in_data;
    logic [NUM_IN-1:0]       in_last;
    logic [SEL_W-1:0]        sel;
    logic                    out_valid;
    logic                    out_ready;
    logic [WIDTH-1:0]        out_data;
    logic                    out_last;
    logic [SEL_W-1:0]        out_sel;

    modport slave (
        input  in_valid, in_data, in_last, sel, out_ready,
        output in_ready, out_valid, out_data, out_last, out_sel
    );

    modport master (
        output in_valid, in_data, in_last, sel, out_ready,
        input  in_ready, out_valid, out_data, out_last, out_sel
    );

endinterface

// File: rtl/otter_stream_mux_rr_arbiter.sv
// Combinational rotating-priority arbiter; ptr_i=0 gives fixed priority.
// open_o marks channels that would win if they requested.
module otter_rr_arbiter #(
    parameter int NUM_IN = 4
) (
    input  logic [NUM_IN-1:0]         req_i,
    input  logic [$clog2(NUM_IN)-1:0] ptr_i,
    output logic [NUM_IN-1:0]         gnt_o,
    output logic [NUM_IN-1:0]         open_o,
    output logic [$clog2(NUM_IN)-1:0] idx_o
);
    localparam int SEL_W = $clog2(NUM_IN);

    logic [SEL_W-1:0] j;
    logic             blocked;

    always_comb begin
        gnt_o   = '0;
        open_o  = '0;
        idx_o   = '0;
        j       = '0;
        blocked = 1'b0;
        for (int off = 0; off < NUM_IN; off++) begin
            j = SEL_W'((int'(ptr_i) + off) % NUM_IN);
            if (!blocked) begin
                open_o[j] = 1'b1;
                if (req_i[j]) begin
                    gnt_o[j] = 1'b1;
                    idx_o    = j;
                    blocked  = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/otter_stream_mux.sv
// N-to-1 stream mux with packet lock and a one-beat output register.
// Arbitration mode is fixed at elaboration time.
module otter_stream_mux
    import otter_mux_pkg::*;
#(
    parameter int        WIDTH    = 32,
    parameter int        NUM_IN   = 4,
    parameter arb_mode_e ARB_MODE = ARB_RR
) (
    input logic            CLK,
    input logic            RST_N,
    otter_stream_mux_if.slave bus
);
    localparam int SEL_W = $clog2(NUM_IN);

    lock_state_e      lock_q;
    logic [SEL_W-1:0] lock_idx_q;
    logic [SEL_W-1:0] rr_ptr_q;
    logic             out_valid_q;
    logic [WIDTH-1:0] out_data_q;
    logic             out_last_q;
    logic [SEL_W-1:0] out_sel_q;

    logic              load_en;
    logic [NUM_IN-1:0] arb_gnt;
    logic [NUM_IN-1:0] arb_open;
    logic [SEL_W-1:0]  arb_idx;
    logic [SEL_W-1:0]  arb_ptr;
    logic [NUM_IN-1:0] avail;
    logic [NUM_IN-1:0] grant;
    logic [SEL_W-1:0]  grant_idx;
    logic [NUM_IN-1:0] xfer;
    logic              any_xfer;
    logic [WIDTH-1:0]  xfer_data;
    logic              xfer_last;

    assign arb_ptr = (ARB_MODE == ARB_RR) ? rr_ptr_q : '0;

    otter_rr_arbiter #(
        .NUM_IN (NUM_IN)
    ) u_arb (
        .req_i  (bus.in_valid),
        .ptr_i  (arb_ptr),
        .gnt_o  (arb_gnt),
        .open_o (arb_open),
        .idx_o  (arb_idx)
    );

    // avail is the set of channels allowed to move this cycle,
    // computed without looking at each channel's own valid.
    always_comb begin
        avail     = '0;
        grant     = '0;
        grant_idx = arb_idx;
        if (lock_q == LOCKED) begin
            for (int i = 0; i < NUM_IN; i++)
                avail[i] = (lock_idx_q == SEL_W'(i));
            grant     = avail & bus.in_valid;
            grant_idx = lock_idx_q;
        end else if (ARB_MODE == ARB_EXT) begin
            for (int i = 0; i < NUM_IN; i++)
                avail[i] = (bus.sel == SEL_W'(i));
            grant     = avail & bus.in_valid;
            grant_idx = bus.sel;
        end else begin
            avail = arb_open;
            grant = arb_gnt;
        end
    end

    assign load_en      = !out_valid_q || bus.out_ready;
    assign bus.in_ready = avail & {NUM_IN{load_en & RST_N}};
    assign xfer         = grant & {NUM_IN{load_en}};
    assign any_xfer     = |xfer;

    always_comb begin
        xfer_data = '0;
        xfer_last = 1'b0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (xfer[i]) begin
                xfer_data = bus.in_data[i*WIDTH +: WIDTH];
                xfer_last = bus.in_last[i];
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            lock_q      <= UNLOCKED;
            lock_idx_q  <= '0;
            rr_ptr_q    <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            out_sel_q   <= '0;
        end else if (any_xfer) begin
            out_valid_q <= 1'b1;
            out_data_q  <= xfer_data;
            out_last_q  <= xfer_last;
            out_sel_q   <= grant_idx;
            if (xfer_last)
                rr_ptr_q <= SEL_W'(wrap_inc(int'(grant_idx), NUM_IN));
            unique case (lock_q)
                UNLOCKED: begin
                    if (!xfer_last) begin
                        lock_q     <= LOCKED;
                        lock_idx_q <= grant_idx;
                    end
                end
                LOCKED: begin
                    if (xfer_last)
                        lock_q <= UNLOCKED;
                end
            endcase
        end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_last  = out_last_q;
    assign bus.out_sel   = out_sel_q;

endmodule

// File: tb/tb_otter_stream_mux.sv
// Directed bench: round-robin instance (4 ch) and external-select instance (5 ch).
module tb_otter_stream_mux;
    import otter_mux_pkg::*;

    logic CLK   = 1'b0;
    logic RST_N = 1'b0;
    int   n_chk = 0;
    int   n_err = 0;

    always #5 CLK = ~CLK;

    otter_stream_mux_if #(.WIDTH(32), .NUM_IN(4)) rr_if ();
    otter_stream_mux_if #(.WIDTH(32), .NUM_IN(5)) ex_if ();

    otter_stream_mux #(
        .WIDTH(32), .NUM_IN(4), .ARB_MODE(ARB_RR)
    ) u_rr (
        .CLK(CLK), .RST_N(RST_N), .bus(rr_if)
    );

    otter_stream_mux #(
        .WIDTH(32), .NUM_IN(5), .ARB_MODE(ARB_EXT)
    ) u_ex (
        .CLK(CLK), .RST_N(RST_N), .bus(ex_if)
    );

    function automatic logic [31:0] wd(int ch, int beat);
        return 32'hA000_0000 | 32'(ch << 8) | 32'(beat);
    endfunction

    function automatic logic [31:0] ew(int ch);
        return 32'hE000_0000 + 32'(ch);
    endfunction

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        rr_if.in_valid  = 4'b1111;
        rr_if.in_last   = 4'b1111;
        rr_if.in_data   = {wd(3, 0), wd(2, 0), wd(1, 0), wd(0, 0)};
        rr_if.sel       = '0;
        rr_if.out_ready = 1'b1;
        ex_if.in_valid  = '0;
        ex_if.in_last   = '1;
        ex_if.in_data   = '0;
        ex_if.sel       = '0;
        ex_if.out_ready = 1'b1;

        #12;
        chk("rst_ov", rr_if.out_valid, 0);
        chk("rst_od", rr_if.out_data, 0);
        chk("rst_last", rr_if.out_last, 0);
        chk("rst_sel", rr_if.out_sel, 0);
        chk("rst_rdy", rr_if.in_ready, 0);
        chk("rst_ex_ov", ex_if.out_valid, 0);

        RST_N = 1'b1;
        settle();
        chk("rel_rdy", rr_if.in_ready, 4'b0001);

        for (int k = 0; k < 6; k++) begin
            step();
            chk("rr_sel", rr_if.out_sel, k % 4);
            chk("rr_ov", rr_if.out_valid, 1);
            chk("rr_od", rr_if.out_data, wd(k % 4, 0));
        end

        // rr_ptr now 2: channel 2 opens a 3-beat packet
        rr_if.in_valid = 4'b0101;
        rr_if.in_last  = 4'b0001;
        rr_if.in_data[2*32 +: 32] = wd(2, 1);
        settle();
        chk("lk_rdy0", rr_if.in_ready, 4'b0100);
        for (int b = 1; b <= 3; b++) begin
            step();
            chk("lk_sel", rr_if.out_sel, 2);
            chk("lk_od", rr_if.out_data, wd(2, b));
            chk("lk_last", rr_if.out_last, (b == 3) ? 1 : 0);
            if (b < 3) begin
                rr_if.in_data[2*32 +: 32] = wd(2, b + 1);
                rr_if.in_last[2] = (b + 1 == 3);
                settle();
                chk("lk_rdy", rr_if.in_ready, 4'b0100);
            end
        end
        rr_if.in_valid[2] = 1'b0;
        settle();
        chk("ul_rdy", rr_if.in_ready, 4'b1001);
        step();
        chk("ul_sel", rr_if.out_sel, 0);

        rr_if.out_ready = 1'b0;
        rr_if.in_data[31:0] = wd(0, 7);
        settle();
        chk("bp_rdy0", rr_if.in_ready, 0);
        for (int c = 0; c < 5; c++) begin
            step();
            chk("bp_od", rr_if.out_data, wd(0, 0));
            chk("bp_ov", rr_if.out_valid, 1);
            chk("bp_rdy", rr_if.in_ready, 0);
        end
        rr_if.out_ready = 1'b1;
        settle();
        chk("bp_rel_rdy", rr_if.in_ready, 4'b1111);
        step();
        chk("bp_nx_od", rr_if.out_data, wd(0, 7));
        chk("bp_nx_ov", rr_if.out_valid, 1);
        rr_if.in_valid = '0;
        step();
        chk("drain_ov", rr_if.out_valid, 0);

        rr_if.in_valid = 4'b1000;
        rr_if.in_last  = 4'b0000;
        rr_if.in_data[3*32 +: 32] = wd(3, 1);
        step();
        chk("mp_sel", rr_if.out_sel, 3);
        chk("mp_ov1", rr_if.out_valid, 1);
        rr_if.in_valid = 4'b1001;
        rr_if.in_data[3*32 +: 32] = wd(3, 2);
        RST_N = 1'b0;
        settle();
        chk("mp_ov0", rr_if.out_valid, 0);
        chk("mp_rdy0", rr_if.in_ready, 0);
        step();
        RST_N = 1'b1;
        settle();
        chk("mp_rel_rdy", rr_if.in_ready, 4'b0001);
        step();
        chk("mp_rel_sel", rr_if.out_sel, 0);
        chk("mp_rel_od", rr_if.out_data, wd(0, 7));
        rr_if.in_valid = '0;

        ex_if.in_valid = '1;
        ex_if.in_last  = '1;
        ex_if.in_data  = {ew(4), ew(3), ew(2), ew(1), ew(0)};
        ex_if.sel      = 3'd1;
        settle();
        chk("ex_rdy1", ex_if.in_ready, 5'b00010);
        step();
        chk("ex_sel1", ex_if.out_sel, 1);
        chk("ex_od1", ex_if.out_data, ew(1));
        ex_if.sel     = 3'd2;
        ex_if.in_last = 5'b11011;
        settle();
        chk("ex_rdy2", ex_if.in_ready, 5'b00100);
        step();
        chk("ex_sel2", ex_if.out_sel, 2);
        chk("ex_last0", ex_if.out_last, 0);
        ex_if.sel = 3'd4;
        settle();
        chk("ex_lk_rdy", ex_if.in_ready, 5'b00100);
        ex_if.in_last = '1;
        step();
        chk("ex_lk_sel", ex_if.out_sel, 2);
        chk("ex_last1", ex_if.out_last, 1);
        chk("ex_rdy4", ex_if.in_ready, 5'b10000);
        ex_if.sel = 3'd5;
        settle();
        chk("ex_rdy5", ex_if.in_ready, 0);
        step();
        chk("ex_ov_drop", ex_if.out_valid, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
